matmul_relu_engine: RTL and testbench

Sequential, parametrised N×N signed matrix multiplier with an optional per-transaction ReLU stage. It replaces the fixed 2×2, purely combinational multiply-then-ReLU datapath with a registered engine that accepts whole matrices over a valid/ready handshake, computes one output row slice per cycle on N shared MAC lanes, and holds the result until the consumer takes it. It sits between the operand-staging logic and the activation/writeback path of the inference datapath.

---
 rtl/matmul_pkg.sv | 24 ++
 rtl/matmul_relu_engine_mac_lane.sv | 30 +++
 rtl/matmul_relu_engine.sv | 139 +++++++++++++
 tb/tb_matmul_relu_engine.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matmul_relu_engine slice.
// Covers engine states, accumulator width, and flat-bus element offsets.
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Wide enough to hold the sum of n full-scale signed products without overflow.
  function automatic int acc_width(input int n, input int dw);
    return 2 * dw + $clog2(n);
  endfunction

  function automatic int ab_lsb(input int r, input int c, input int n, input int dw);
    return (r * n + c) * dw;
  endfunction

  function automatic int c_lsb(input int r, input int c, input int n, input int aw);
    return (r * n + c) * aw;
  endfunction

endpackage

// File: rtl/matmul_relu_engine_mac_lane.sv
// One MAC lane: a signed DWxDW multiply whose product is sign-extended and
// added to an externally stored AW-bit accumulator value.
module mac_lane
  import matmul_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 33
) (
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  input  logic signed [AW-1:0] acc_in,
  output logic signed [AW-1:0] acc_out
);

  logic signed [2*DW-1:0] prod;

  assign prod = a * b;

  always_comb begin
    acc_out = acc_in;
    if (clr) begin
      acc_out = '0;
    end else if (en) begin
      acc_out = acc_in + AW'(prod);
    end
  end

endmodule

// File: rtl/matmul_relu_engine.sv
// Sequential NxN signed matrix multiplier with optional ReLU on the result.
// One row slice (N MACs) per cycle; the result is held until the consumer takes it.
module matmul_relu_engine
  import matmul_pkg::*;
#(
  parameter int N  = 2,
  parameter int DW = 16,
  parameter int AW = acc_width(N, DW)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                relu_en,
  input  logic [N*N*DW-1:0]   a_flat,
  input  logic [N*N*DW-1:0]   b_flat,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N*N*AW-1:0]   c_flat
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t                state_reg, state_next;
  logic [CW-1:0]         i_reg, k_reg;
  logic                  relu_reg;
  logic signed [DW-1:0]  a_reg   [N][N];
  logic signed [DW-1:0]  b_reg   [N][N];
  logic signed [AW-1:0]  acc_reg [N][N];
  logic signed [AW-1:0]  lane_out [N];
  logic                  accept;
  logic                  step;

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    step       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = COMPUTE;
        end
      end
      COMPUTE: begin
        step = 1'b1;
        if (i_reg == LAST && k_reg == LAST) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // k walks the inner dimension; i advances to the next row when k wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_reg    <= '0;
      k_reg    <= '0;
      relu_reg <= 1'b0;
    end else if (accept) begin
      i_reg    <= '0;
      k_reg    <= '0;
      relu_reg <= relu_en;
    end else if (step) begin
      if (k_reg == LAST) begin
        k_reg <= '0;
        i_reg <= (i_reg == LAST) ? '0 : i_reg + 1'b1;
      end else begin
        k_reg <= k_reg + 1'b1;
      end
    end
  end

  // Lanes output zero while clr is high, so the accept cycle clears every row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          a_reg[r][c]   <= '0;
          b_reg[r][c]   <= '0;
          acc_reg[r][c] <= '0;
        end
      end
    end else begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          if (accept) begin
            a_reg[r][c]   <= a_flat[ab_lsb(r, c, N, DW) +: DW];
            b_reg[r][c]   <= b_flat[ab_lsb(r, c, N, DW) +: DW];
            acc_reg[r][c] <= lane_out[c];
          end else if (step && i_reg == CW'(r)) begin
            acc_reg[r][c] <= lane_out[c];
          end
        end
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    mac_lane #(
      .DW(DW),
      .AW(AW)
    ) u_lane (
      .clr     (accept),
      .en      (step),
      .a       (a_reg[i_reg][k_reg]),
      .b       (b_reg[k_reg][gi]),
      .acc_in  (acc_reg[i_reg][gi]),
      .acc_out (lane_out[gi])
    );
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      assign c_flat[c_lsb(gi, gj, N, AW) +: AW] =
        (relu_reg && acc_reg[gi][gj][AW-1]) ? '0 : acc_reg[gi][gj];
    end
  end

endmodule

// File: tb/tb_matmul_relu_engine.sv
// Self-checking bench: a cycle-level behavioural model of the N=2 engine checked
// every cycle, directed literal cases, and an N=4 instance for the overflow extreme.
module tb_matmul_relu_engine;

  localparam int N2   = 2;
  localparam int N4   = 4;
  localparam int DW   = 16;
  localparam int AW2  = 33;
  localparam int AW4  = 34;
  localparam int ABW2 = N2 * N2 * DW;
  localparam int CW2  = N2 * N2 * AW2;
  localparam int ABW4 = N4 * N4 * DW;
  localparam int CW4  = N4 * N4 * AW4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            in_valid, in_ready, relu_en, out_valid, out_ready;
  logic [ABW2-1:0] a_flat, b_flat;
  logic [CW2-1:0]  c_flat;

  logic            in_valid4, in_ready4, relu_en4, out_valid4, out_ready4;
  logic [ABW4-1:0] a4, b4;
  logic [CW4-1:0]  c4;

  matmul_relu_engine #(.N(N2), .DW(DW)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .relu_en(relu_en), .a_flat(a_flat), .b_flat(b_flat),
    .out_valid(out_valid), .out_ready(out_ready), .c_flat(c_flat)
  );

  matmul_relu_engine #(.N(N4), .DW(DW)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .relu_en(relu_en4), .a_flat(a4), .b_flat(b4),
    .out_valid(out_valid4), .out_ready(out_ready4), .c_flat(c4)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int tx_cyc[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // Reference product straight from the definition of matrix multiply.
  function automatic logic [CW2-1:0] ref_c2(input logic [ABW2-1:0] a, input logic [ABW2-1:0] b,
                                            input logic relu);
    logic [CW2-1:0] res;
    longint s;
    res = '0;
    for (int r = 0; r < N2; r++) begin
      for (int c = 0; c < N2; c++) begin
        s = 0;
        for (int k = 0; k < N2; k++) begin
          s += longint'($signed(a[(r*N2+k)*DW +: DW])) * longint'($signed(b[(k*N2+c)*DW +: DW]));
        end
        if (relu && s < 0) s = 0;
        res[(r*N2+c)*AW2 +: AW2] = s[AW2-1:0];
      end
    end
    return res;
  endfunction

  function automatic logic [ABW2-1:0] pack2(input int e0, input int e1, input int e2, input int e3);
    logic [ABW2-1:0] v;
    v[0*DW +: DW] = 16'(e0);
    v[1*DW +: DW] = 16'(e1);
    v[2*DW +: DW] = 16'(e2);
    v[3*DW +: DW] = 16'(e3);
    return v;
  endfunction

  function automatic longint el2(input int r, input int c);
    return longint'($signed(c_flat[(r*N2+c)*AW2 +: AW2]));
  endfunction

  // Behavioural model: engine is idle, busy for N*N cycles after accept, then holds the result.
  typedef enum {M_IDLE, M_COMPUTE, M_DONE} mstate_t;
  mstate_t        m_state = M_IDLE;
  int             m_cnt = 0;
  int             m_tx = 0;
  logic [CW2-1:0] m_c = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_c_flat", c_flat, '0);
      m_state = M_IDLE;
      m_c     = '0;
    end else begin
      chk("in_ready", in_ready, m_state == M_IDLE);
      chk("out_valid", out_valid, m_state == M_DONE);
      if (m_state != M_COMPUTE) chk("c_flat", c_flat, m_c);
      case (m_state)
        M_IDLE: if (in_valid) begin
          m_c     = ref_c2(a_flat, b_flat, relu_en);
          m_cnt   = N2 * N2;
          m_state = M_COMPUTE;
          m_tx++;
          $display("tx %0d accepted at cycle %0d relu=%0b a=%h b=%h", m_tx, cyc, relu_en, a_flat, b_flat);
        end
        M_COMPUTE: begin
          m_cnt--;
          if (m_cnt == 0) m_state = M_DONE;
        end
        M_DONE: if (out_ready) m_state = M_IDLE;
        default: m_state = M_IDLE;
      endcase
    end
  end

  task automatic send2(input logic [ABW2-1:0] a, input logic [ABW2-1:0] b, input logic relu);
    in_valid = 1'b1;
    a_flat   = a;
    b_flat   = b;
    relu_en  = relu;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready) begin
        tx_cyc.push_back(cyc);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    timeout_fail("send2");
    in_valid = 1'b0;
  endtask

  task automatic wait_out2(output int lat);
    lat = -1;
    for (int t = 1; t <= 60; t++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = t;
        return;
      end
    end
    timeout_fail("wait_out2");
  endtask

  task automatic basic_case(input string tag);
    int lat;
    send2(pack2(1, 2, 3, 4), pack2(5, 6, 7, 8), 1'b0);
    wait_out2(lat);
    chk({tag, "_latency"}, lat, 5);
    chk({tag, "_c00"}, el2(0, 0), 19);
    chk({tag, "_c01"}, el2(0, 1), 22);
    chk({tag, "_c10"}, el2(1, 0), 43);
    chk({tag, "_c11"}, el2(1, 1), 50);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    int base;
    bit got;
    in_valid = 1'b0; relu_en = 1'b0; out_ready = 1'b1; a_flat = '0; b_flat = '0;
    in_valid4 = 1'b0; relu_en4 = 1'b0; out_ready4 = 1'b1; a4 = '0; b4 = '0;

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    basic_case("basic");

    send2(pack2(1, -2, 3, -4), pack2(5, 6, 7, 8), 1'b0);
    wait_out2(lat);
    chk("neg_c00", el2(0, 0), -9);
    chk("neg_c01", el2(0, 1), -10);
    chk("neg_c10", el2(1, 0), -13);
    chk("neg_c11", el2(1, 1), -14);
    @(posedge clk); #1;

    send2(pack2(1, -2, 3, -4), pack2(5, 6, 7, 8), 1'b1);
    wait_out2(lat);
    for (int e = 0; e < 4; e++) chk("relu_c", el2(e / 2, e % 2), 0);
    @(posedge clk); #1;

    send2(pack2(-32768, -32768, -32768, -32768), pack2(-32768, -32768, -32768, -32768), 1'b0);
    wait_out2(lat);
    for (int e = 0; e < 4; e++) chk("ext2_c", el2(e / 2, e % 2), 64'sd2147483648);
    @(posedge clk); #1;

    // N=4 extreme: sum of four 2^30 products needs the 34-bit accumulator.
    a4 = {16{16'h8000}};
    b4 = {16{16'h8000}};
    in_valid4 = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      if (in_ready4) got = 1'b1;
      @(posedge clk); #1;
    end
    in_valid4 = 1'b0;
    if (!got) timeout_fail("n4_accept");
    got = 1'b0;
    for (int t = 0; t < 60 && !got; t++) begin
      @(negedge clk);
      if (out_valid4) got = 1'b1;
    end
    if (!got) timeout_fail("n4_done");
    else for (int e = 0; e < 16; e++) chk("ext4_c", c4[e*AW4 +: AW4], 34'h1_0000_0000);
    @(posedge clk); #1;

    // Backpressure with new data toggling on the inputs.
    out_ready = 1'b0;
    send2({$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
    wait_out2(lat);
    for (int t = 0; t < 10; t++) begin
      @(posedge clk); #1;
      in_valid = 1'(t % 2);
      a_flat   = {$urandom, $urandom};
      b_flat   = {$urandom, $urandom};
      relu_en  = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_out_valid", out_valid, 1'b1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send2({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    wait_out2(lat);
    @(posedge clk); #1;

    // Reset during the second COMPUTE cycle.
    send2({$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_c_flat", c_flat, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    basic_case("post_rst");

    // Throughput: three back-to-back transactions with out_ready high.
    base = tx_cyc.size();
    for (int t = 0; t < 3; t++) begin
      send2({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    end
    wait_out2(lat);
    chk("tput_gap1", tx_cyc[base+1] - tx_cyc[base], 6);
    chk("tput_gap2", tx_cyc[base+2] - tx_cyc[base+1], 6);
    @(posedge clk); #1;

    // Random traffic on both handshakes, checked cycle by cycle by the model.
    for (int t = 0; t < 400; t++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      relu_en   = 1'($urandom_range(0, 1));
      a_flat    = {$urandom, $urandom};
      b_flat    = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
